mac_host_driver: RTL and testbench

Host-side driver for the 8-bit MAC accelerator pin interface. It accepts operand pairs over a valid/ready stream into a small FIFO and issues them onto the accelerator's ui_in/uio_in pins. It waits out the accelerator latency, captures the 8-bit result from the accelerator's C output, and returns it on a valid/ready result stream. It then pulses an accumulator clear before the next vector. It sits between the system bus/test sequencer and the MAC accelerator, on the opposite side of the accelerator's operand/result pins.

---
 rtl/mac_host_driver.sv | 202 ++++++++++++++++++++
 tb/tb_mac_host_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_host_driver.sv
// mac_host_driver: host-side driver for the 8-bit MAC accelerator pins.
//   Operand pairs {in_last,in_a,in_b} enter a FIFO over a valid/ready stream.
//   Pairs are issued on dut_a/dut_b with dut_ena. After the accelerator
//   latency, dut_c is captured and returned on out_*. A one-cycle dut_clr
//   pulse follows each returned result.
// Ports:
//   clk, rst                        clock, async active-high reset
//   in_valid/in_ready/in_a/in_b/in_last   operand-pair input stream
//   dut_a, dut_b, dut_ena, dut_clr  accelerator operand/control pins
//   dut_c                           accelerator result
//   out_valid/out_ready/out_data/out_count  result stream
//   busy                            FSM active or FIFO non-empty
// Optional: define RESULT_CHECK_EN to add chk_err, a sticky flag set when a
// captured result differs from an internal reference accumulator.
module mac_host_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAC_LAT    = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       dut_a,
  output logic [7:0]       dut_b,
  output logic             dut_ena,
  output logic             dut_clr,
  input  logic [7:0]       dut_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
`ifdef RESULT_CHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(MAC_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic [16:0]      mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;
  logic [16:0]      head;

  logic [2:0]       state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       dut_a_q, dut_a_d, dut_b_q, dut_b_d;
  logic             dut_ena_q, dut_ena_d, dut_clr_q, dut_clr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  // Extra pointer bit distinguishes full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready = !rst && !full;
    push     = in_valid && in_ready;
    head     = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_a, in_b};
  end

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    dut_a_d     = '0;
    dut_b_d     = '0;
    dut_ena_d   = 1'b0;
    dut_clr_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!empty) begin
          pop       = 1'b1;
          dut_a_d   = head[15:8];
          dut_b_d   = head[7:0];
          dut_ena_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (head[16]) begin
            state_d = S_WAIT;
            lat_d   = LW'(MAC_LAT);
          end
        end
      end
      // Stays MAC_LAT+1 cycles so capture lands MAC_LAT+1 after the last ena.
      S_WAIT: begin
        if (lat_q == '0) begin
          out_data_d  = dut_c;
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      // dut_clr is registered here so it is high exactly while in CLEAR.
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          dut_clr_d   = 1'b1;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      state_q     <= S_IDLE;
      lat_q       <= '0;
      cnt_q       <= '0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
      dut_ena_q   <= 1'b0;
      dut_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      state_q     <= state_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
      dut_ena_q   <= dut_ena_d;
      dut_clr_q   <= dut_clr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign dut_ena   = dut_ena_q;
  assign dut_clr   = dut_clr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign busy      = (state_q != S_IDLE) || !empty;

`ifdef RESULT_CHECK_EN
  logic [7:0]  ref_q, ref_d;
  logic        chk_err_q, chk_err_d;
  logic [15:0] prod;

  always_comb begin
    ref_d     = ref_q;
    chk_err_d = chk_err_q;
    prod      = head[15:8] * head[7:0];
    if (pop) ref_d = ref_q + prod[7:0];
    if (state_q == S_CLEAR) ref_d = '0;
    if (state_q == S_WAIT && lat_q == '0 && dut_c != ref_q) chk_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      ref_q     <= ref_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_mac_host_driver.sv
// Directed testbench for mac_host_driver with a behavioural MAC accelerator.
module tb_mac_host_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;
  logic       in_ready;
  logic [7:0] dut_a, dut_b, dut_c;
  logic       dut_ena, dut_clr;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic [7:0] out_count;
  logic       busy;
`ifdef RESULT_CHECK_EN
  logic       chk_err;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0]  acc;
  logic        force_zero = 1'b0;
  logic [15:0] ena_log[$];
  int          clr_cnt = 0;

  always #5 clk = ~clk;

  mac_host_driver #(.FIFO_DEPTH(4), .MAC_LAT(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .dut_a(dut_a), .dut_b(dut_b), .dut_ena(dut_ena), .dut_clr(dut_clr), .dut_c(dut_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .busy(busy)
`ifdef RESULT_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  // Accelerator model: accumulates a*b mod 256 per enabled pair.
  always @(posedge clk or posedge rst) begin
    if (rst) acc <= 8'h00;
    else if (dut_clr) acc <= 8'h00;
    else if (dut_ena) acc <= acc + (dut_a * dut_b);
  end
  assign dut_c = force_zero ? 8'h00 : acc;

  always @(negedge clk) begin
    if (!rst && dut_ena) ena_log.push_back({dut_a, dut_b});
    if (dut_clr) clr_cnt++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b, input logic l,
                           output logic ok);
    int n;
    n = 0; ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = l;
    while (!ok && n < 50) begin
      if (in_ready === 1'b1) ok = 1'b1;
      tick();
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic to);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    to = (out_valid !== 1'b1);
  endtask

  task automatic handshake;
    out_ready = 1'b1; tick(); out_ready = 1'b0; tick();
  endtask

  task automatic test_reset;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if ({out_valid, dut_ena, dut_clr} !== 3'b000) begin bad++; $display("FAIL rst_outs: got %b want 000", {out_valid, dut_ena, dut_clr}); end
    rst = 1'b0; tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    in_valid = 1'b1; in_a = 8'd3; in_b = 8'd4; in_last = 1'b0; tick();
    in_a = 8'd5; in_b = 8'd6; in_last = 1'b1; tick();
    total++; if (dut_ena !== 1'b0) begin bad++; $display("FAIL basic_ena_early: got %b want 0", dut_ena); end
    in_valid = 1'b0; in_last = 1'b0; tick();
    total++; if ({dut_ena, dut_a, dut_b} !== {1'b1, 8'd3, 8'd4}) begin bad++; $display("FAIL basic_pair1: got %h want 10304", {dut_ena, dut_a, dut_b}); end
    tick();
    total++; if ({dut_ena, dut_a, dut_b} !== {1'b1, 8'd5, 8'd6}) begin bad++; $display("FAIL basic_pair2: got %h want 10506", {dut_ena, dut_a, dut_b}); end
    tick();
    total++; if ({dut_ena, dut_a, dut_b, out_valid} !== 18'h0) begin bad++; $display("FAIL basic_wait1: got %h want 0", {dut_ena, dut_a, dut_b, out_valid}); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_wait2: got %b want 0", out_valid); end
    tick();
    total++; if ({out_valid, out_data, out_count} !== {1'b1, 8'h2A, 8'd2}) begin bad++; $display("FAIL basic_result: got %h want 12a02", {out_valid, out_data, out_count}); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if ({out_valid, dut_clr} !== 2'b01) begin bad++; $display("FAIL basic_clr: got %b want 01", {out_valid, dut_clr}); end
    tick();
    total++; if ({dut_clr, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle: got %b want 00", {dut_clr, busy}); end
`ifdef RESULT_CHECK_EN
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL basic_chk: got %b want 0", chk_err); end
`endif
  endtask

  task automatic test_wrap;
    logic ok, to;
    push_pair(8'hFF, 8'hFF, 1'b1, ok);
    wait_valid(to);
    total++; if (!ok || to) begin bad++; $display("FAIL wrap_timeout: got ok=%b to=%b want ok=1 to=0", ok, to); end
    total++; if ({out_data, out_count} !== {8'h01, 8'd1}) begin bad++; $display("FAIL wrap_result: got %h want 0101", {out_data, out_count}); end
    handshake();
  endtask

  task automatic test_gap;
    logic ok, to;
    ena_log.delete();
    push_pair(8'd4, 8'd5, 1'b0, ok);
    tick(); tick(); tick(); tick();
    total++; if (ena_log.size() != 1 || dut_ena !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL gap_idle: got n=%0d ena=%b busy=%b want n=1 ena=0 busy=1", ena_log.size(), dut_ena, busy); end
    push_pair(8'd6, 8'd7, 1'b1, ok);
    wait_valid(to);
    total++; if (to) begin bad++; $display("FAIL gap_timeout: got to=1 want 0"); end
    total++; if ({out_data, out_count} !== {8'h3E, 8'd2}) begin bad++; $display("FAIL gap_result: got %h want 3e02", {out_data, out_count}); end
    total++; if (ena_log.size() != 2) begin bad++; $display("FAIL gap_enas: got %0d want 2", ena_log.size()); end
    handshake();
  endtask

  task automatic test_back_to_back;
    logic ok, to;
    logic [15:0] exp;
    push_pair(8'd1, 8'd1, 1'b1, ok);
    wait_valid(to);
    push_pair(8'd1, 8'd2, 1'b0, ok);
    push_pair(8'd3, 8'd4, 1'b0, ok);
    push_pair(8'd5, 8'd6, 1'b0, ok);
    push_pair(8'd7, 8'd8, 1'b0, ok);
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd10; in_last = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got in_ready=%b want 0", in_ready); end
    total++; if ({out_valid, out_data, out_count} !== {1'b1, 8'h01, 8'd1}) begin bad++; $display("FAIL bp_hold: got %h want 10101", {out_valid, out_data, out_count}); end
    ena_log.delete();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_pair(8'd9, 8'd10, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_push5: got ok=0 want 1"); end
    wait_valid(to);
    total++; if (to || {out_data, out_count} !== {8'hBE, 8'd5}) begin bad++; $display("FAIL bp_result: got to=%b %h want to=0 be05", to, {out_data, out_count}); end
    total++;
    if (ena_log.size() != 5) begin
      bad++; $display("FAIL bp_order_n: got %0d want 5", ena_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp = {8'(2*i+1), 8'(2*i+2)};
        if (ena_log[i] !== exp) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, ena_log[i], exp); end
      end
    end
    handshake();
  endtask

  task automatic test_reset_wait;
    logic ok, to;
    push_pair(8'd1, 8'd1, 1'b1, ok);
    tick(); tick();
    total++; if (dut_ena !== 1'b1) begin bad++; $display("FAIL rw_ena: got %b want 1", dut_ena); end
    clr_cnt = 0;
    rst = 1'b1; #1;
    total++; if ({in_ready, dut_ena, dut_a, dut_b, dut_clr, out_valid, out_data, out_count, busy} !== 36'h0) begin bad++; $display("FAIL rw_async: got %h want 0", {in_ready, dut_ena, dut_a, dut_b, dut_clr, out_valid, out_data, out_count, busy}); end
    tick(); tick();
    rst = 1'b0;
    push_pair(8'd2, 8'd2, 1'b1, ok);
    wait_valid(to);
    total++; if (to || {out_data, out_count} !== {8'h04, 8'd1}) begin bad++; $display("FAIL rw_next: got to=%b %h want to=0 0401", to, {out_data, out_count}); end
    total++; if (clr_cnt != 0) begin bad++; $display("FAIL rw_noclr: got %0d want 0", clr_cnt); end
    handshake();
  endtask

`ifdef RESULT_CHECK_EN
  task automatic test_chk;
    logic ok, to;
    force_zero = 1'b1;
    push_pair(8'd1, 8'd1, 1'b1, ok);
    wait_valid(to);
    force_zero = 1'b0;
    total++; if (to || out_data !== 8'h00 || chk_err !== 1'b1) begin bad++; $display("FAIL chk_set: got to=%b d=%h err=%b want 0 00 1", to, out_data, chk_err); end
    handshake();
    push_pair(8'd2, 8'd3, 1'b1, ok);
    wait_valid(to);
    total++; if (to || out_data !== 8'h06 || chk_err !== 1'b1) begin bad++; $display("FAIL chk_sticky: got to=%b d=%h err=%b want 0 06 1", to, out_data, chk_err); end
    handshake();
    rst = 1'b1; #1;
    total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_rst: got %b want 0", chk_err); end
    tick(); rst = 1'b0; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gap();
    test_back_to_back();
    test_reset_wait();
`ifdef RESULT_CHECK_EN
    test_chk();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
